trap_controller: RTL and testbench
==================================

# trap_controller

Sequential, parametrised trap controller for the pipelined core: it replaces the combinational exception decode with a registered, multi-source trap unit. It captures the faulting PC and a prioritised cause into SEPC/SCAUSE, flushes the pipeline for a configurable number of cycles, and redirects fetch to the trap vector through a valid/ready handshake. It returns to SEPC on `sret` and flags nested traps as a sticky double fault.

## Interface
- `PC_W`, 15, width of PC and redirect address
- `XLEN`, 64, width of SCAUSE
- `NUM_SRC`, 4, number of trap sources; index 0 has highest priority
- `INFO_W`, 15, per-source info field width; must satisfy INFO_W ≤ XLEN − IDX_W
- `IDX_W`, 3, width of the source-index field in SCAUSE; 2^IDX_W ≥ NUM_SRC
- `FLUSH_CYCLES`, 2, cycles `flush` is held high, range 1..15
- `TVEC`, 15'h1F00, trap handler entry address
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `pc`  in  PC_W  PC of the instruction in EXE
- `src_req`  in  NUM_SRC  per-source trap request; core mapping is 0 mem-read size, 1 mem-write size, 2 illegal ALUOp, 3 branch target out of range
- `src_info`  in  NUM_SRC*INFO_W  packed info; source i occupies bits [i*INFO_W +: INFO_W]
- `sret`  in  1  return-from-trap strobe
- `redirect_ready`  in  1  fetch accepts redirect
- `sepc`  out  PC_W  captured PC
- `scause`  out  XLEN  {source index (IDX_W), zeros, info (INFO_W)}
- `trap_taken`  out  1  one-cycle pulse on capture
- `flush`  out  1  kill IF/ID/EXE contents
- `redirect_valid`  out  1  redirect request
- `redirect_pc`  out  PC_W  target: TVEC or sepc
- `busy`  out  1  state ≠ IDLE
- `double_fault`  out  1  sticky nested-trap flag
- `trap_count`  out  16  saturating count of taken traps

## Operation
- FSM states: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- IDLE: if any `src_req` bit is set, select the lowest set index k and perform the capture. The capture writes `sepc` ← `pc` and `scause` ← {k, 0, info_k}, pulses `trap_taken`, increments `trap_count` (saturating at 16'hFFFF), loads the flush counter with FLUSH_CYCLES, and moves to FLUSH. `sret` in IDLE is ignored.
- FLUSH: `flush` is 1. The counter decrements each cycle; when it reaches 1, the FSM moves to REDIRECT.
- REDIRECT: `redirect_valid` is 1 and `redirect_pc` is TVEC, both held stable until `redirect_ready`. On the handshake cycle the FSM moves to HANDLER.
- HANDLER: `sret` moves the FSM to RETURN. Any `src_req` sets `double_fault` and leaves SEPC, SCAUSE and `trap_count` unchanged; the FSM stays in HANDLER. If `src_req` and `sret` arrive in the same cycle, the trap wins: `double_fault` is set and `sret` is dropped.
- RETURN: `redirect_valid` is 1 and `redirect_pc` is `sepc`, held until `redirect_ready`, then the FSM moves to IDLE.
- `src_req` is ignored in FLUSH, REDIRECT and RETURN.
- When `redirect_valid` is 0, `redirect_pc` reads 0.
- `double_fault` clears only on reset.

## Timing
- Reset (async, `rst_n` = 0) forces: state IDLE; `sepc`, `scause`, `trap_count` = 0; `trap_taken`, `flush`, `redirect_valid`, `busy`, `double_fault` = 0; `redirect_pc` = 0. Asserting reset mid-operation aborts the sequence immediately, with no pending redirect.
- Request sampled at edge N → at N+1: `sepc`/`scause` valid, `trap_taken` = 1 for that one cycle, `flush` = 1, `busy` = 1.
- `flush` is high for exactly FLUSH_CYCLES cycles (N+1 … N+FLUSH_CYCLES). `redirect_valid` rises at N+FLUSH_CYCLES+1.
- With `redirect_ready` tied high, REDIRECT lasts 1 cycle and HANDLER begins at N+FLUSH_CYCLES+2.
- `sret` at edge M in HANDLER → `redirect_valid` with `sepc` from M+1. With ready high, IDLE at M+2; a new trap can be accepted from M+2.
- All outputs are registered or decoded from state only; there is no combinational path from `src_req` to any output.

## Test plan
- Single trap: `pc` = 15'h0123, `src_req` = 4'b0100, info2 = 15'h0009, FLUSH_CYCLES = 2, ready = 1 → `sepc` = 0123, `scause` = {3'd2, 0, 15'h0009}; `flush` high 2 cycles; `redirect_pc` = 1F00 for 1 cycle; `trap_count` = 1.
- Priority: `src_req` = 4'b1010, info1 = 15'h0003 → `scause` index 1, info 0003; sources 3 and 2 are not recorded.
- Back-pressure: ready held low for 5 cycles in REDIRECT → `redirect_valid` and `redirect_pc` = 1F00 stable for all 5 cycles; HANDLER is entered only after ready rises.
- Return: `sret` in HANDLER → `redirect_pc` = 0123; IDLE after the handshake; `sret` in IDLE produces no output change.
- Nested trap: `src_req` and `sret` in the same HANDLER cycle → `double_fault` = 1, `sepc`/`scause`/`trap_count` unchanged, FSM stays in HANDLER; flag persists until reset.
- Reset mid-FLUSH → all outputs 0 asynchronously; a trap issued after release is captured normally and `trap_count` restarts at 1.

Source files
------------

// File: rtl/trap_controller.sv
// Registered multi-source trap unit: captures SEPC/SCAUSE, flushes the pipeline,
// redirects fetch to TVEC, returns to SEPC on sret, flags nested traps.
module trap_controller #(
    parameter int PC_W         = 15,
    parameter int XLEN         = 64,
    parameter int NUM_SRC      = 4,
    parameter int INFO_W       = 15,
    parameter int IDX_W        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter logic [PC_W-1:0] TVEC = 15'h1F00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PC_W-1:0]           pc,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*INFO_W-1:0] src_info,
    input  logic                      sret,
    input  logic                      redirect_ready,
    output logic [PC_W-1:0]           sepc,
    output logic [XLEN-1:0]           scause,
    output logic                      trap_taken,
    output logic                      flush,
    output logic                      redirect_valid,
    output logic [PC_W-1:0]           redirect_pc,
    output logic                      busy,
    output logic                      double_fault,
    output logic [15:0]               trap_count
);

    typedef enum logic [2:0] {
        IDLE, FLUSH, REDIRECT, HANDLER, RETURN
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   sepc_q, sepc_d;
    logic [XLEN-1:0]   scause_q, scause_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              taken_q, taken_d;
    logic              dfault_q, dfault_d;
    logic [15:0]       count_q, count_d;

    logic              req_any;
    logic [IDX_W-1:0]  sel_idx;
    logic [INFO_W-1:0] sel_info;

    assign req_any = |src_req;

    // Scan high to low so the lowest set index is the one that survives.
    always_comb begin
        sel_idx  = '0;
        sel_info = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                sel_idx  = IDX_W'(i);
                sel_info = src_info[i*INFO_W +: INFO_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sepc_d   = sepc_q;
        scause_d = scause_q;
        cnt_d    = cnt_q;
        taken_d  = 1'b0;
        dfault_d = dfault_q;
        count_d  = count_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    sepc_d   = pc;
                    scause_d = '0;
                    scause_d[XLEN-1 -: IDX_W] = sel_idx;
                    scause_d[INFO_W-1:0]      = sel_info;
                    taken_d  = 1'b1;
                    if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    cnt_d    = 4'(FLUSH_CYCLES);
                    state_d  = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q <= 4'd1) state_d = REDIRECT;
                else cnt_d = cnt_q - 4'd1;
            end
            REDIRECT: begin
                if (redirect_ready) state_d = HANDLER;
            end
            HANDLER: begin
                // A trap arriving with sret wins; the return is dropped.
                if (req_any) dfault_d = 1'b1;
                else if (sret) state_d = RETURN;
            end
            RETURN: begin
                if (redirect_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sepc_q   <= '0;
            scause_q <= '0;
            cnt_q    <= '0;
            taken_q  <= 1'b0;
            dfault_q <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sepc_q   <= sepc_d;
            scause_q <= scause_d;
            cnt_q    <= cnt_d;
            taken_q  <= taken_d;
            dfault_q <= dfault_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        redirect_pc = '0;
        if (state_q == REDIRECT) redirect_pc = TVEC;
        else if (state_q == RETURN) redirect_pc = sepc_q;
    end

    assign sepc           = sepc_q;
    assign scause         = scause_q;
    assign trap_taken     = taken_q;
    assign flush          = (state_q == FLUSH);
    assign redirect_valid = (state_q == REDIRECT) || (state_q == RETURN);
    assign busy           = (state_q != IDLE);
    assign double_fault   = dfault_q;
    assign trap_count     = count_q;

endmodule

// File: tb/tb_trap_controller.sv
// Directed table-driven bench for trap_controller plus an async-reset
// sequence in the middle of a flush.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] pc;
    logic [3:0]  src_req;
    logic [59:0] src_info;
    logic        sret;
    logic        redirect_ready;
    logic [14:0] sepc;
    logic [63:0] scause;
    logic        trap_taken;
    logic        flush;
    logic        redirect_valid;
    logic [14:0] redirect_pc;
    logic        busy;
    logic        double_fault;
    logic [15:0] trap_count;

    trap_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .src_req        (src_req),
        .src_info       (src_info),
        .sret           (sret),
        .redirect_ready (redirect_ready),
        .sepc           (sepc),
        .scause         (scause),
        .trap_taken     (trap_taken),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .double_fault   (double_fault),
        .trap_count     (trap_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] pc;
        logic [3:0]  req;
        logic [59:0] info;
        logic        sret;
        logic        rdy;
        logic [14:0] e_sepc;
        logic [63:0] e_scause;
        logic        e_tt;
        logic        e_fl;
        logic        e_rv;
        logic [14:0] e_rpc;
        logic        e_busy;
        logic        e_df;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [63:0] mk(input logic [2:0] i, input logic [14:0] f);
        return {i, 46'b0, f};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [14:0] p, input logic [3:0] r, input logic [59:0] inf,
                       input logic s, input logic rd, input logic [14:0] es,
                       input logic [63:0] ec, input logic tt, input logic fl,
                       input logic rv, input logic [14:0] rpc, input logic bz,
                       input logic df, input logic [15:0] cnt);
        vec_t v;
        v.pc = p; v.req = r; v.info = inf; v.sret = s; v.rdy = rd;
        v.e_sepc = es; v.e_scause = ec; v.e_tt = tt; v.e_fl = fl;
        v.e_rv = rv; v.e_rpc = rpc; v.e_busy = bz; v.e_df = df; v.e_cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic chk_all(input string p, input vec_t v);
        chk({p, ".sepc"}, 64'(sepc), 64'(v.e_sepc));
        chk({p, ".scause"}, scause, v.e_scause);
        chk({p, ".trap_taken"}, 64'(trap_taken), 64'(v.e_tt));
        chk({p, ".flush"}, 64'(flush), 64'(v.e_fl));
        chk({p, ".redirect_valid"}, 64'(redirect_valid), 64'(v.e_rv));
        chk({p, ".redirect_pc"}, 64'(redirect_pc), 64'(v.e_rpc));
        chk({p, ".busy"}, 64'(busy), 64'(v.e_busy));
        chk({p, ".double_fault"}, 64'(double_fault), 64'(v.e_df));
        chk({p, ".trap_count"}, 64'(trap_count), 64'(v.e_cnt));
    endtask

    initial begin
        logic [59:0] i_a, i_b;
        logic [63:0] c_a, c_b;
        vec_t z;
        i_a = {15'h0, 15'h0009, 15'h0, 15'h0};
        i_b = {15'h7777, 15'h5555, 15'h0003, 15'h0};
        c_a = mk(3'd2, 15'h0009);
        c_b = mk(3'd1, 15'h0003);

        // single trap, return, sret ignored in IDLE
        add(15'h0123, 4'b0100, i_a, 0, 1, 15'h0123, c_a, 1, 1, 0, 15'h0,    1, 0, 1);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0123, c_a, 0, 1, 0, 15'h0,    1, 0, 1);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0123, c_a, 0, 0, 1, 15'h1F00, 1, 0, 1);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0123, c_a, 0, 0, 0, 15'h0,    1, 0, 1);
        add(15'h0000, 4'b0000, 0,   1, 1, 15'h0123, c_a, 0, 0, 1, 15'h0123, 1, 0, 1);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0123, c_a, 0, 0, 0, 15'h0,    0, 0, 1);
        add(15'h0000, 4'b0000, 0,   1, 1, 15'h0123, c_a, 0, 0, 0, 15'h0,    0, 0, 1);
        // priority, requests ignored in FLUSH/REDIRECT, back-pressure
        add(15'h0456, 4'b1010, i_b, 0, 1, 15'h0456, c_b, 1, 1, 0, 15'h0,    1, 0, 2);
        add(15'h0777, 4'b1010, i_b, 0, 1, 15'h0456, c_b, 0, 1, 0, 15'h0,    1, 0, 2);
        add(15'h0000, 4'b0000, 0,   0, 0, 15'h0456, c_b, 0, 0, 1, 15'h1F00, 1, 0, 2);
        add(15'h0000, 4'b0000, 0,   0, 0, 15'h0456, c_b, 0, 0, 1, 15'h1F00, 1, 0, 2);
        add(15'h0000, 4'b0001, i_a, 0, 0, 15'h0456, c_b, 0, 0, 1, 15'h1F00, 1, 0, 2);
        add(15'h0000, 4'b0000, 0,   0, 0, 15'h0456, c_b, 0, 0, 1, 15'h1F00, 1, 0, 2);
        add(15'h0000, 4'b0000, 0,   0, 0, 15'h0456, c_b, 0, 0, 1, 15'h1F00, 1, 0, 2);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0456, c_b, 0, 0, 0, 15'h0,    1, 0, 2);
        // nested trap with simultaneous sret
        add(15'h0999, 4'b0001, i_a, 1, 1, 15'h0456, c_b, 0, 0, 0, 15'h0,    1, 1, 2);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0456, c_b, 0, 0, 0, 15'h0,    1, 1, 2);
        add(15'h0000, 4'b0000, 0,   1, 1, 15'h0456, c_b, 0, 0, 1, 15'h0456, 1, 1, 2);
        add(15'h0000, 4'b0000, 0,   0, 1, 15'h0456, c_b, 0, 0, 0, 15'h0,    0, 1, 2);

        rst_n = 1'b0; pc = '0; src_req = '0; src_info = '0;
        sret = 1'b0; redirect_ready = 1'b0;
        repeat (2) @(negedge clk);
        z = '{default: '0};
        chk_all("reset", z);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            pc = vq[i].pc; src_req = vq[i].req; src_info = vq[i].info;
            sret = vq[i].sret; redirect_ready = vq[i].rdy;
            @(posedge clk);
            @(negedge clk);
            chk_all($sformatf("v%0d", i), vq[i]);
        end

        // async reset in the middle of a flush
        pc = 15'h0321; src_req = 4'b0010; src_info = i_b; redirect_ready = 1'b1; sret = 1'b0;
        @(posedge clk);
        @(negedge clk);
        src_req = '0;
        chk("mid.flush", 64'(flush), 64'd1);
        chk("mid.count", 64'(trap_count), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        z = '{default: '0};
        chk_all("async", z);
        @(negedge clk);
        rst_n = 1'b1;
        pc = 15'h0042; src_req = 4'b1000; src_info = {15'h0011, 45'h0};
        @(posedge clk);
        @(negedge clk);
        src_req = '0;
        chk("post.sepc", 64'(sepc), 64'h0042);
        chk("post.scause", scause, mk(3'd3, 15'h0011));
        chk("post.count", 64'(trap_count), 64'd1);
        chk("post.df", 64'(double_fault), 64'd0);
        chk("post.tt", 64'(trap_taken), 64'd1);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("post.rv", 64'(redirect_valid), 64'd1);
        chk("post.rpc", 64'(redirect_pc), 64'h1F00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
